// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the combinational I-cache read port,
// and buffers returned instructions in a 2-entry queue toward decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ic_rd_addr,
    output logic        ic_rd_req,
    input  logic        ic_rd_wait,
    input  logic [31:0] ic_rd_data,
    input  logic        jmp,
    input  logic [31:0] jmp_pc,
    input  logic        stall,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid,
    output logic [31:0] miss_cycles
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] miss_q, miss_d;
    logic [31:0] q_pc_q   [2];
    logic [31:0] q_insn_q [2];

    logic accept;
    logic pop;
    logic unused_jmp_pc_lsbs;

    assign unused_jmp_pc_lsbs = ^jmp_pc[1:0];

    // Request is deliberately independent of stall: no stall-to-cache timing path.
    assign ic_rd_req  = !rst && !jmp && (count_q < 2'd2);
    assign ic_rd_addr = fetch_pc_q;
    assign accept     = ic_rd_req && !ic_rd_wait;
    assign insn_valid = (count_q != 2'd0);
    assign pop        = insn_valid && !stall && !jmp;

    assign insn        = q_insn_q[rd_ptr_q];
    assign insn_pc     = q_pc_q[rd_ptr_q];
    assign miss_cycles = miss_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        miss_d     = miss_q;

        if (ic_rd_req && ic_rd_wait && (miss_q != 32'hFFFF_FFFF)) begin
            miss_d = miss_q + 32'd1;
        end

        if (jmp) begin
            fetch_pc_d = {jmp_pc[31:2], 2'b00};
            count_d    = 2'd0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({accept, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            miss_q     <= 32'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            miss_q     <= miss_d;
        end
    end

    // Storage is cleared on reset so the head outputs read as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                q_pc_q[i]   <= 32'd0;
                q_insn_q[i] <= 32'd0;
            end
        end else if (accept) begin
            q_pc_q[wr_ptr_q]   <= fetch_pc_q;
            q_insn_q[wr_ptr_q] <= ic_rd_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the cache is modelled as data = addr ^ 32'hA5A5A5A5 with a
// bench-driven wait line; every expected value below is hand-computed.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] XMASK  = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ic_rd_addr;
    logic        ic_rd_req;
    logic        ic_rd_wait;
    logic [31:0] ic_rd_data;
    logic        jmp;
    logic [31:0] jmp_pc;
    logic        stall;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic [31:0] miss_cycles;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign ic_rd_data = ic_rd_addr ^ XMASK;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .ic_rd_addr (ic_rd_addr),
        .ic_rd_req  (ic_rd_req),
        .ic_rd_wait (ic_rd_wait),
        .ic_rd_data (ic_rd_data),
        .jmp        (jmp),
        .jmp_pc     (jmp_pc),
        .stall      (stall),
        .insn       (insn),
        .insn_pc    (insn_pc),
        .insn_valid (insn_valid),
        .miss_cycles(miss_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(insn_valid), 32'd1);
        chk({tag, "_pc"}, insn_pc, pc);
        chk({tag, "_insn"}, insn, pc ^ XMASK);
    endtask

    initial begin
        rst = 1'b1; jmp = 1'b0; jmp_pc = 32'd0; stall = 1'b0; ic_rd_wait = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_req", 32'(ic_rd_req), 32'd0);
        chk("rst_valid", 32'(insn_valid), 32'd0);
        chk("rst_addr", ic_rd_addr, 32'h100);
        chk("rst_miss", miss_cycles, 32'd0);
        chk("rst_insn", insn, 32'd0);
        chk("rst_insn_pc", insn_pc, 32'd0);

        // Streaming, all hits, no stall: one per cycle from the cycle after the first request
        rst = 1'b0;
        #1;
        chk("first_req", 32'(ic_rd_req), 32'd1);
        chk("first_addr", ic_rd_addr, 32'h100);
        chk("first_valid", 32'(insn_valid), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_head("stream", 32'h100 + 32'(4 * i));
            chk("stream_req", 32'(ic_rd_req), 32'd1);
            tick();
        end

        // Stall from reset: queue fills with 0x100,0x104 then request drops
        rst = 1'b1; stall = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("st_req1", 32'(ic_rd_req), 32'd1);
        tick();
        chk_head("st_c2", 32'h100);
        chk("st_req2", 32'(ic_rd_req), 32'd1);
        chk("st_addr2", ic_rd_addr, 32'h104);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_head("st_full", 32'h100);
            chk("st_full_req", 32'(ic_rd_req), 32'd0);
            chk("st_full_addr", ic_rd_addr, 32'h108);
            tick();
        end
        stall = 1'b0;
        #1;
        chk_head("rel0", 32'h100);
        chk("rel0_req", 32'(ic_rd_req), 32'd0);
        tick();
        chk_head("rel1", 32'h104);
        chk("rel1_req", 32'(ic_rd_req), 32'd1);
        chk("rel1_addr", ic_rd_addr, 32'h108);
        tick();
        chk_head("rel2", 32'h108);
        tick();
        chk_head("rel3", 32'h10C);

        // Jump to 0x200 then miss there for 4 cycles
        jmp = 1'b1; jmp_pc = 32'h200;
        #1;
        chk("jmp_req", 32'(ic_rd_req), 32'd0);
        tick();
        jmp = 1'b0; ic_rd_wait = 1'b1;
        #1;
        chk("miss_base", miss_cycles, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("miss_addr", ic_rd_addr, 32'h200);
            chk("miss_req", 32'(ic_rd_req), 32'd1);
            chk("miss_valid", 32'(insn_valid), 32'd0);
            tick();
        end
        ic_rd_wait = 1'b0;
        #1;
        chk("miss_count", miss_cycles, 32'd4);
        chk("miss_end_addr", ic_rd_addr, 32'h200);
        tick();
        chk_head("miss_deliver", 32'h200);

        // Fill queue, then jump to unaligned 0x403 with two entries pending
        stall = 1'b1;
        tick();
        chk_head("full_pre_jmp", 32'h200);
        chk("full_req", 32'(ic_rd_req), 32'd0);
        jmp = 1'b1; jmp_pc = 32'h403;
        #1;
        chk("jmp2_req", 32'(ic_rd_req), 32'd0);
        tick();
        jmp = 1'b0; stall = 1'b0;
        #1;
        chk("jmp2_valid", 32'(insn_valid), 32'd0);
        chk("jmp2_addr", ic_rd_addr, 32'h400);
        chk("jmp2_req_after", 32'(ic_rd_req), 32'd1);
        tick();
        chk_head("jmp2_t0", 32'h400);
        tick();
        chk_head("jmp2_t1", 32'h404);

        // Address wrap at the top of the space
        jmp = 1'b1; jmp_pc = 32'hFFFF_FFF8;
        tick();
        jmp = 1'b0;
        #1;
        chk("wrap_addr", ic_rd_addr, 32'hFFFF_FFF8);
        chk("wrap_valid0", 32'(insn_valid), 32'd0);
        tick();
        chk_head("wrap0", 32'hFFFF_FFF8);
        tick();
        chk_head("wrap1", 32'hFFFF_FFFC);
        tick();
        chk_head("wrap2", 32'h0000_0000);

        // Miss then fill to full, then rst together with jmp
        stall = 1'b1; ic_rd_wait = 1'b1;
        #1;
        chk("pre_rst_addr", ic_rd_addr, 32'h4);
        tick();
        tick();
        ic_rd_wait = 1'b0;
        tick();
        ic_rd_wait = 1'b1;
        #1;
        chk("pre_rst_req", 32'(ic_rd_req), 32'd0);
        chk("pre_rst_miss", miss_cycles, 32'd6);
        chk_head("pre_rst_head", 32'h0);
        rst = 1'b1; jmp = 1'b1; jmp_pc = 32'h800;
        #1;
        chk("rst_jmp_req", 32'(ic_rd_req), 32'd0);
        tick();
        rst = 1'b0; jmp = 1'b0; ic_rd_wait = 1'b0; stall = 1'b0;
        #1;
        chk("post_rst_valid", 32'(insn_valid), 32'd0);
        chk("post_rst_addr", ic_rd_addr, 32'h100);
        chk("post_rst_miss", miss_cycles, 32'd0);
        chk("post_rst_req", 32'(ic_rd_req), 32'd1);
        tick();
        chk_head("post_rst_first", 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
